// File: rtl/icache_refill_ctrl_pkg.sv
// Shared instruction-cache definitions: default geometry, derived widths,
// refill FSM states, PLRU state type and the tree-PLRU access update.
package icache_refill_ctrl_pkg;

    localparam int CACHE_WAYS       = 4;
    localparam int CACHE_SETS       = 64;
    localparam int CACHE_LINE_WORDS = 8;

    localparam int WORD_OFF_W = $clog2(CACHE_LINE_WORDS);
    localparam int OFFSET_W   = WORD_OFF_W + 2;
    localparam int INDEX_W    = $clog2(CACHE_SETS);

    // Sized for the widest legal geometry; a 2-way cache only uses bit 0.
    typedef logic [CACHE_WAYS-2:0] plru_state_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_REFILL,
        ST_FLUSH
    } refill_state_e;

    // Mark `way` most recently used: the tree bits on its path point away from it.
    function automatic plru_state_t plru_access(input plru_state_t p,
                                                input logic [1:0]  way,
                                                input logic        four_way);
        plru_state_t n;
        n = p;
        if (four_way) begin
            if (!way[1]) begin
                n[2] = 1'b1;
                n[1] = ~way[0];
            end else begin
                n[2] = 1'b0;
                n[0] = ~way[0];
            end
        end else begin
            n[0] = ~way[0];
        end
        return n;
    endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Victim way selection (lowest invalid way, else tree PLRU) and the PLRU
// next state for an access to a given way. Purely combinational.
module cache_victim_sel
    import icache_refill_ctrl_pkg::*;
#(
    parameter int SET_ASSOC = CACHE_WAYS,
    parameter int WAY_W     = $clog2(SET_ASSOC)
) (
    input  logic [SET_ASSOC-1:0] valid_i,
    input  plru_state_t          plru_i,
    input  logic [WAY_W-1:0]     access_way_i,
    output logic [WAY_W-1:0]     victim_o,
    output plru_state_t          plru_next_o
);

    logic [1:0] plru_pick;

    always_comb begin
        if (SET_ASSOC == 4) begin
            plru_pick = plru_i[2] ? {1'b1, plru_i[0]} : {1'b0, plru_i[1]};
        end else begin
            plru_pick = {1'b0, plru_i[0]};
        end
        victim_o = WAY_W'(plru_pick);
        // Scan downwards so the lowest invalid way is the one left standing.
        for (int w = SET_ASSOC - 1; w >= 0; w--) begin
            if (!valid_i[w]) begin
                victim_o = WAY_W'(w);
            end
        end
    end

    assign plru_next_o = plru_access(plru_i, 2'(access_way_i), SET_ASSOC == 4);

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss/refill controller: per-set valid and PLRU flops,
// burst line refill into the data/tag arrays, and a full invalidate sweep.
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
#(
    parameter int SET_ASSOC  = CACHE_WAYS,
    parameter int SETS       = CACHE_SETS,
    parameter int LINE_WORDS = CACHE_LINE_WORDS,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          lookup_valid,
    input  logic [$clog2(SETS)-1:0]       lookup_index,
    input  logic                          lookup_hit,
    input  logic [SET_ASSOC-1:0]          lookup_way,
    output logic [SET_ASSOC-1:0]          set_valid,
    input  logic                          miss_valid,
    output logic                          miss_ready,
    input  logic [ADDR_WIDTH-1:0]         miss_addr,
    output logic                          mem_req,
    input  logic                          mem_ready,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    input  logic                          mem_rvalid,
    input  logic [31:0]                   mem_rdata,
    output logic                          wr_en,
    output logic [$clog2(SET_ASSOC)-1:0]  wr_way,
    output logic [$clog2(SETS)-1:0]       wr_index,
    output logic [$clog2(LINE_WORDS)-1:0] wr_word,
    output logic [31:0]                   wr_data,
    output logic                          tag_we,
    output logic                          refill_done,
    input  logic                          flush_req,
    output logic                          flush_done
);

    localparam int WAY_W  = $clog2(SET_ASSOC);
    localparam int IDX_W  = $clog2(SETS);
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WORD_W + 2;

    refill_state_e         state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WAY_W-1:0]      victim_q, victim_d;
    logic [WORD_W-1:0]     beat_q, beat_d;
    logic [IDX_W-1:0]      fcnt_q, fcnt_d;

    logic [SET_ASSOC-1:0]  valid_q [SETS];
    plru_state_t           plru_q  [SETS];

    logic [IDX_W-1:0]      miss_idx;
    logic [IDX_W-1:0]      sel_index;
    logic [WAY_W-1:0]      sel_victim;
    plru_state_t           sel_plru_next;
    logic [WAY_W-1:0]      hit_way;
    plru_state_t           hit_plru;
    logic                  miss_acc;
    logic                  commit;
    logic                  hit_upd;

    assign miss_idx = miss_addr[OFF_W +: IDX_W];
    // Victim is picked in the missing set while idle; during refill the
    // same selector supplies the commit-time PLRU update of the latched set.
    assign sel_index = (state_q == ST_IDLE) ? miss_idx : idx_q;

    cache_victim_sel #(
        .SET_ASSOC (SET_ASSOC),
        .WAY_W     (WAY_W)
    ) u_victim_sel (
        .valid_i      (valid_q[sel_index]),
        .plru_i       (plru_q[sel_index]),
        .access_way_i (victim_q),
        .victim_o     (sel_victim),
        .plru_next_o  (sel_plru_next)
    );

    always_comb begin
        hit_way = '0;
        for (int w = 0; w < SET_ASSOC; w++) begin
            if (lookup_way[w]) begin
                hit_way = hit_way | WAY_W'(w);
            end
        end
    end

    assign hit_plru  = plru_access(plru_q[lookup_index], 2'(hit_way), SET_ASSOC == 4);
    assign set_valid = valid_q[lookup_index];
    assign miss_acc  = (state_q == ST_IDLE) && !flush_req && miss_valid;
    assign commit    = (state_q == ST_REFILL) && mem_rvalid && (beat_q == WORD_W'(LINE_WORDS - 1));
    assign hit_upd   = lookup_valid && lookup_hit && (state_q != ST_FLUSH);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        victim_d    = victim_q;
        beat_d      = beat_q;
        fcnt_d      = fcnt_q;
        miss_ready  = 1'b0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        wr_en       = 1'b0;
        wr_way      = '0;
        wr_index    = '0;
        wr_word     = '0;
        wr_data     = '0;
        tag_we      = 1'b0;
        refill_done = 1'b0;
        flush_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                miss_ready = !flush_req;
                if (flush_req) begin
                    fcnt_d  = '0;
                    state_d = ST_FLUSH;
                end else if (miss_valid) begin
                    idx_d    = miss_idx;
                    addr_d   = {miss_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    victim_d = sel_victim;
                    beat_d   = '0;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
                if (mem_ready) begin
                    state_d = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (mem_rvalid) begin
                    wr_en    = 1'b1;
                    wr_way   = victim_q;
                    wr_index = idx_q;
                    wr_word  = beat_q;
                    wr_data  = mem_rdata;
                    beat_d   = beat_q + 1'b1;
                    if (commit) begin
                        tag_we      = 1'b1;
                        refill_done = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                fcnt_d = fcnt_q + 1'b1;
                if (fcnt_q == IDX_W'(SETS - 1)) begin
                    flush_done = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            addr_q   <= '0;
            victim_q <= '0;
            beat_q   <= '0;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            victim_q <= victim_d;
            beat_q   <= beat_d;
            fcnt_q   <= fcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < SETS; s++) begin
                if ((state_q == ST_FLUSH) && (fcnt_q == IDX_W'(s))) begin
                    valid_q[s] <= '0;
                    plru_q[s]  <= '0;
                end else begin
                    if (miss_acc && (miss_idx == IDX_W'(s))) begin
                        valid_q[s][sel_victim] <= 1'b0;
                    end
                    // A refill commit outranks a same-cycle hit to the same set.
                    if (commit && (idx_q == IDX_W'(s))) begin
                        valid_q[s][victim_q] <= 1'b1;
                        plru_q[s]            <= sel_plru_next;
                    end else if (hit_upd && (lookup_index == IDX_W'(s))) begin
                        plru_q[s] <= hit_plru;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: refill sequencing, victim/PLRU order,
// handshake stalls, hit-vs-commit priority, flush sweep and mid-refill reset.
module tb_icache_refill_ctrl;
    import icache_refill_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        lookup_valid;
    logic [5:0]  lookup_index;
    logic        lookup_hit;
    logic [3:0]  lookup_way;
    logic [3:0]  set_valid;
    logic        miss_valid;
    logic        miss_ready;
    logic [31:0] miss_addr;
    logic        mem_req;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wr_en;
    logic [1:0]  wr_way;
    logic [5:0]  wr_index;
    logic [2:0]  wr_word;
    logic [31:0] wr_data;
    logic        tag_we;
    logic        refill_done;
    logic        flush_req;
    logic        flush_done;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    icache_refill_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .lookup_valid (lookup_valid),
        .lookup_index (lookup_index),
        .lookup_hit   (lookup_hit),
        .lookup_way   (lookup_way),
        .set_valid    (set_valid),
        .miss_valid   (miss_valid),
        .miss_ready   (miss_ready),
        .miss_addr    (miss_addr),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .wr_en        (wr_en),
        .wr_way       (wr_way),
        .wr_index     (wr_index),
        .wr_word      (wr_word),
        .wr_data      (wr_data),
        .tag_we       (tag_we),
        .refill_done  (refill_done),
        .flush_req    (flush_req),
        .flush_done   (flush_done)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic hit(input logic [5:0] idx, input logic [3:0] way_oh);
        lookup_valid = 1'b1;
        lookup_hit   = 1'b1;
        lookup_index = idx;
        lookup_way   = way_oh;
        next_cycle();
        lookup_valid = 1'b0;
        lookup_hit   = 1'b0;
        lookup_way   = '0;
    endtask

    // Full back-to-back miss; optional hit to the same set on the commit beat.
    task automatic do_miss(input logic [31:0] a, input int exp_way,
                           input logic hit_on_commit, input logic [3:0] hit_way_oh);
        logic [5:0]  idx;
        logic [31:0] data;
        idx = a[OFFSET_W +: INDEX_W];
        miss_valid = 1'b1;
        miss_addr  = a;
        #2;
        check_eq("miss_ready", miss_ready, 1'b1);
        next_cycle();
        miss_valid = 1'b0;
        mem_ready  = 1'b1;
        #2;
        check_eq("mem_req", mem_req, 1'b1);
        check_eq("mem_addr", mem_addr, a & 32'hFFFF_FFE0);
        next_cycle();
        mem_ready = 1'b0;
        for (int b = 0; b < 8; b++) begin
            data       = a ^ (32'h0101_0101 * b);
            mem_rvalid = 1'b1;
            mem_rdata  = data;
            if (hit_on_commit && b == 7) begin
                lookup_valid = 1'b1;
                lookup_hit   = 1'b1;
                lookup_index = idx;
                lookup_way   = hit_way_oh;
            end
            #2;
            check_eq("wr_en", wr_en, 1'b1);
            check_eq("wr_word", wr_word, b);
            check_eq("wr_way", wr_way, exp_way);
            check_eq("wr_index", wr_index, idx);
            check_eq("wr_data", wr_data, data);
            check_eq("tag_we", tag_we, b == 7);
            check_eq("refill_done", refill_done, b == 7);
            next_cycle();
        end
        mem_rvalid   = 1'b0;
        lookup_valid = 1'b0;
        lookup_hit   = 1'b0;
        lookup_way   = '0;
        lookup_index = idx;
        #2;
        check_eq("set_valid_way", set_valid[exp_way], 1'b1);
        $display("[TB] refill addr=0x%08h index=0x%02h way=%0d", a, idx, exp_way);
        next_cycle();
    endtask

    initial begin
        int nwr;
        int ndone;
        int done_at;
        int first_done;

        rst          = 1'b1;
        lookup_valid = 1'b0;
        lookup_index = 6'h11;
        lookup_hit   = 1'b0;
        lookup_way   = '0;
        miss_valid   = 1'b0;
        miss_addr    = '0;
        mem_ready    = 1'b0;
        mem_rvalid   = 1'b0;
        mem_rdata    = '0;
        flush_req    = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #2;
        check_eq("rst_miss_ready", miss_ready, 1'b1);
        check_eq("rst_mem_req", mem_req, 1'b0);
        check_eq("rst_wr_en", wr_en, 1'b0);
        check_eq("rst_set_valid", set_valid, 4'b0000);
        check_eq("rst_refill_done", refill_done, 1'b0);
        check_eq("rst_flush_done", flush_done, 1'b0);
        check_eq("rst_tag_we", tag_we, 1'b0);
        next_cycle();

        // First miss: index 0x11, line 0x1220, way 0.
        do_miss(32'h0000_1234, 0, 1'b0, 4'b0000);
        lookup_index = 6'h11;
        #2;
        check_eq("first_set_valid", set_valid, 4'b0001);
        next_cycle();

        // Set 5: fill, hit 0,2,1 -> victim 3, then victim 0.
        do_miss(32'h1000_00A0, 0, 1'b0, 4'b0000);
        do_miss(32'h2000_00A0, 1, 1'b0, 4'b0000);
        do_miss(32'h3000_00A0, 2, 1'b0, 4'b0000);
        do_miss(32'h4000_00A0, 3, 1'b0, 4'b0000);
        hit(6'd5, 4'b0001);
        hit(6'd5, 4'b0100);
        hit(6'd5, 4'b0010);
        do_miss(32'h5000_00A0, 3, 1'b0, 4'b0000);
        do_miss(32'h6000_00A0, 0, 1'b0, 4'b0000);

        // Request stall and gapped beats on set 7.
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_20E4;
        next_cycle();
        miss_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #2;
            check_eq("stall_mem_req", mem_req, 1'b1);
            check_eq("stall_mem_addr", mem_addr, 32'h0000_20E0);
            next_cycle();
        end
        mem_ready = 1'b1;
        #2;
        check_eq("stall_accept_req", mem_req, 1'b1);
        next_cycle();
        mem_ready = 1'b0;
        nwr     = 0;
        ndone   = 0;
        done_at = -1;
        for (int c = 0; c < 30; c++) begin
            mem_rvalid = (c % 3 == 0);
            mem_rdata  = c;
            #2;
            if (wr_en) nwr++;
            if (refill_done) begin
                ndone++;
                done_at = c;
            end
            next_cycle();
        end
        mem_rvalid = 1'b0;
        check_eq("gap_writes", nwr, 8);
        check_eq("gap_done_pulses", ndone, 1);
        check_eq("gap_done_cycle", done_at, 21);

        // Set 9: hit to way 2 on the commit of way 0; commit must win.
        do_miss(32'h1000_0120, 0, 1'b0, 4'b0000);
        do_miss(32'h2000_0120, 1, 1'b0, 4'b0000);
        do_miss(32'h3000_0120, 2, 1'b0, 4'b0000);
        do_miss(32'h4000_0120, 3, 1'b0, 4'b0000);
        do_miss(32'h5000_0120, 0, 1'b1, 4'b0100);
        do_miss(32'h6000_0120, 2, 1'b0, 4'b0000);

        // Flush and miss together: flush first, miss right after.
        flush_req  = 1'b1;
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_1234;
        #2;
        check_eq("flush_miss_ready", miss_ready, 1'b0);
        next_cycle();
        flush_req  = 1'b0;
        first_done = 0;
        for (int k = 1; k <= 80; k++) begin
            #2;
            if (k == 1) check_eq("flushing_miss_ready", miss_ready, 1'b0);
            if (flush_done && first_done == 0) first_done = k;
            next_cycle();
            if (first_done != 0) break;
        end
        check_eq("flush_done_cycle", first_done, 64);
        lookup_index = 6'd5;
        #1;
        check_eq("flush_set5", set_valid, 4'b0000);
        lookup_index = 6'd9;
        #1;
        check_eq("flush_set9", set_valid, 4'b0000);
        lookup_index = 6'd7;
        #1;
        check_eq("flush_set7", set_valid, 4'b0000);
        do_miss(32'h0000_1234, 0, 1'b0, 4'b0000);
        $display("[TB] flush done after %0d cycles", first_done);

        // Reset during beat 3 of a refill into set 0x11 (victim way 1).
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_5234;
        next_cycle();
        miss_valid = 1'b0;
        mem_ready  = 1'b1;
        next_cycle();
        mem_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hA5A5_0000 + b;
            #2;
            if (b == 0) check_eq("rst_test_victim", wr_way, 1);
            if (b == 3) rst = 1'b1;
            next_cycle();
        end
        rst          = 1'b0;
        lookup_index = 6'h11;
        #2;
        check_eq("rst_mid_mem_req", mem_req, 1'b0);
        check_eq("rst_mid_wr_en", wr_en, 1'b0);
        check_eq("rst_mid_refill_done", refill_done, 1'b0);
        check_eq("rst_mid_miss_ready", miss_ready, 1'b1);
        check_eq("rst_mid_set_valid", set_valid, 4'b0000);
        next_cycle();
        mem_rvalid = 1'b0;
        $display("[TB] reset during refill beat 3");
        do_miss(32'h0000_5234, 0, 1'b0, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
